// File: rtl/conv_sched_pkg.sv
// Shared types, response codes and descriptor layout for the convolution
// layer scheduler and its round-robin arbiter.
package conv_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        ERR_OK      = 2'd0,
        ERR_CFG     = 2'd1,
        ERR_TIMEOUT = 2'd2
    } rsp_err_t;

    localparam int CFG_W = 58;

    localparam int OFF_KERNEL = 0;
    localparam int OFF_STRIDE = 8;
    localparam int OFF_PAD    = 16;
    localparam int OFF_HEIGHT = 24;
    localparam int OFF_WIDTH  = 32;
    localparam int OFF_IN_CH  = 40;
    localparam int OFF_OUT_CH = 48;
    localparam int OFF_ACT    = 56;

    // Padded image span (dim + 2*pad) is formed in 10 bits so it never wraps.
    function automatic logic window_too_small(input logic [7:0] dim,
                                              input logic [7:0] pad,
                                              input logic [7:0] k);
        logic [9:0] span;
        span = {2'b00, dim} + {1'b0, pad, 1'b0};
        return span < {2'b00, k};
    endfunction

endpackage

// File: rtl/conv_rr_arbiter.sv
// Round-robin arbiter: requester 0 first after reset, priority moves to the
// requester after the last winner whenever a grant is taken (advance).
module conv_rr_arbiter #(
    parameter int NUM_REQ = 2,
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id
);

    logic [ID_W-1:0] ptr;
    logic            found;
    int              idx;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = ID_W'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
        end
    end

endmodule

// File: rtl/conv_layer_scheduler.sv
// Shares one convolution datapath among NUM_REQ requesters: grant, check the
// descriptor, pulse the datapath, wait, respond. CONV_SCHED_TIMEOUT_EN adds a WAIT watchdog.
module conv_layer_scheduler
    import conv_sched_pkg::*;
#(
    parameter int NUM_REQ          = 2,
    parameter int MAX_IMG_HEIGHT   = 32,
    parameter int MAX_IMG_WIDTH    = 32,
    parameter int MAX_IN_CHANNELS  = 3,
    parameter int MAX_OUT_CHANNELS = 16,
    parameter int MAX_KERNEL_SIZE  = 5,
    parameter int TIMEOUT_CYCLES   = 1024,
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*CFG_W-1:0] req_cfg,
    output logic                     conv_valid_in,
    output logic [7:0]               conv_kernel_size,
    output logic [7:0]               conv_stride,
    output logic [7:0]               conv_padding,
    output logic [7:0]               conv_img_height,
    output logic [7:0]               conv_img_width,
    output logic [7:0]               conv_in_channels,
    output logic [7:0]               conv_out_channels,
    output logic [1:0]               conv_activation,
    input  logic                     conv_valid_out,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [1:0]               rsp_err,
    output logic                     busy,
    output logic [2:0]               state_dbg
);

    // Handshakes: a requester transfer happens in a cycle where req_valid[i]
    // and req_ready[i] are both high; a response transfer where rsp_valid and
    // rsp_ready are both high. Valids never depend on the matching ready.

    state_t               state, state_nxt;
    logic [CFG_W-1:0]     cfg_q;
    logic [ID_W-1:0]      id_q;
    logic [1:0]           err_q;
    logic [NUM_REQ-1:0]   grant;
    logic [ID_W-1:0]      grant_id;
    logic                 accept;
    logic                 cfg_bad;
    logic                 timeout_hit;

    conv_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk      (clk),
        .rst      (rst),
        .req      (req_valid),
        .advance  (accept),
        .grant    (grant),
        .grant_id (grant_id)
    );

    assign accept    = (state == ST_IDLE) && !rst && (|req_valid);
    assign req_ready = accept ? grant : '0;

    assign conv_kernel_size  = cfg_q[OFF_KERNEL +: 8];
    assign conv_stride       = cfg_q[OFF_STRIDE +: 8];
    assign conv_padding      = cfg_q[OFF_PAD    +: 8];
    assign conv_img_height   = cfg_q[OFF_HEIGHT +: 8];
    assign conv_img_width    = cfg_q[OFF_WIDTH  +: 8];
    assign conv_in_channels  = cfg_q[OFF_IN_CH  +: 8];
    assign conv_out_channels = cfg_q[OFF_OUT_CH +: 8];
    assign conv_activation   = cfg_q[OFF_ACT    +: 2];

    // Limits compared in 10 bits so oversize parameters cannot alias.
    always_comb begin
        cfg_bad = (conv_kernel_size == 8'd0) || (conv_stride == 8'd0) ||
                  (conv_in_channels == 8'd0) || (conv_out_channels == 8'd0) ||
                  ({2'b00, conv_kernel_size}  > 10'(MAX_KERNEL_SIZE))  ||
                  ({2'b00, conv_img_height}   > 10'(MAX_IMG_HEIGHT))   ||
                  ({2'b00, conv_img_width}    > 10'(MAX_IMG_WIDTH))    ||
                  ({2'b00, conv_in_channels}  > 10'(MAX_IN_CHANNELS))  ||
                  ({2'b00, conv_out_channels} > 10'(MAX_OUT_CHANNELS)) ||
                  window_too_small(conv_img_height, conv_padding, conv_kernel_size) ||
                  window_too_small(conv_img_width,  conv_padding, conv_kernel_size);
    end

`ifdef CONV_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (rst || state != ST_WAIT) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign timeout_hit = (state == ST_WAIT) && !conv_valid_out &&
                         (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept) state_nxt = ST_CHECK;
            ST_CHECK: state_nxt = cfg_bad ? ST_RESP : ST_ISSUE;
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT:  if (conv_valid_out || timeout_hit) state_nxt = ST_RESP;
            ST_RESP:  if (rsp_ready) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cfg_q <= '0;
            id_q  <= '0;
            err_q <= ERR_OK;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cfg_q <= req_cfg[grant_id*CFG_W +: CFG_W];
                id_q  <= grant_id;
            end
            if (state == ST_CHECK) begin
                err_q <= cfg_bad ? ERR_CFG : ERR_OK;
            end
            if (state == ST_WAIT && !conv_valid_out && timeout_hit) begin
                err_q <= ERR_TIMEOUT;
            end
        end
    end

    assign conv_valid_in = (state == ST_ISSUE);
    assign rsp_valid     = (state == ST_RESP);
    assign rsp_id        = id_q;
    assign rsp_err       = err_q;
    assign busy          = (state != ST_IDLE);
    assign state_dbg     = state;

endmodule

// File: tb/tb_conv_layer_scheduler.sv
// Bench for conv_layer_scheduler: scoreboarded jobs, arbitration, descriptor
// checks, response hold, reset abandonment and the optional watchdog.
module tb_conv_layer_scheduler;

    localparam int N   = 2;
    localparam int CW  = 58;
    localparam int TO  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*CW-1:0]   req_cfg;
    logic              conv_valid_in;
    logic [7:0]        conv_kernel_size, conv_stride, conv_padding, conv_img_height;
    logic [7:0]        conv_img_width, conv_in_channels, conv_out_channels;
    logic [1:0]        conv_activation;
    logic              conv_valid_out = 1'b0;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [0:0]        rsp_id;
    logic [1:0]        rsp_err;
    logic              busy;
    logic [2:0]        state_dbg;

    conv_layer_scheduler #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_cfg(req_cfg),
        .conv_valid_in(conv_valid_in), .conv_kernel_size(conv_kernel_size),
        .conv_stride(conv_stride), .conv_padding(conv_padding),
        .conv_img_height(conv_img_height), .conv_img_width(conv_img_width),
        .conv_in_channels(conv_in_channels), .conv_out_channels(conv_out_channels),
        .conv_activation(conv_activation), .conv_valid_out(conv_valid_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_err(rsp_err),
        .busy(busy), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [CW-1:0] mk(input int k, s, p, h, w, ic, oc, act);
        logic [CW-1:0] c;
        c = {act[1:0], oc[7:0], ic[7:0], w[7:0], h[7:0], p[7:0], s[7:0], k[7:0]};
        return c;
    endfunction

    function automatic bit exp_bad(input logic [CW-1:0] c);
        int k, s, p, h, w, ic, oc;
        k = c[7:0];   s = c[15:8];  p = c[23:16]; h = c[31:24];
        w = c[39:32]; ic = c[47:40]; oc = c[55:48];
        return (k == 0) || (s == 0) || (ic == 0) || (oc == 0) || (k > 5) || (h > 32) ||
               (w > 32) || (ic > 3) || (oc > 16) || (h + 2*p < k) || (w + 2*p < k);
    endfunction

    // datapath model: answers one cycle after the start pulse when enabled
    bit dp_en    = 1'b1;
    bit dp_force = 1'b0;
    bit dp_seen  = 1'b0;
    always @(negedge clk) dp_seen = conv_valid_in;
    always @(posedge clk) begin
        #1;
        conv_valid_out = (dp_seen && dp_en) || dp_force;
    end

    // scoreboard
    logic [2:0]     exp_q[$];
    int             lat_q[$];
    int             acc_q[$];
    int             grant_log[$];
    int             rr_ptr   = 0;
    int             n_issue  = 0;
    bit             rsp_prev = 1'b0;
    bit             cur_bad  = 1'b0;
    logic [CW-1:0]  cur_cfg  = '0;

    function automatic logic [CW-1:0] conv_fields();
        return {conv_activation, conv_out_channels, conv_in_channels, conv_img_width,
                conv_img_height, conv_padding, conv_stride, conv_kernel_size};
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            rr_ptr   = 0;
            rsp_prev = 1'b0;
        end else begin
            if (req_ready != '0) begin
                int gid, ew, lat;
                logic [1:0] e;
                gid = 0;
                ew  = -1;
                for (int i = 0; i < N; i++) if (req_ready[i]) gid = i;
                for (int k = N - 1; k >= 0; k--) if (req_valid[(rr_ptr + k) % N]) ew = (rr_ptr + k) % N;
                check_eq("ready_onehot", $countones(req_ready), 1);
                check_eq("ready_without_valid", req_ready & ~req_valid, 0);
                check_eq("rr_winner", gid, ew);
                rr_ptr  = (gid + 1) % N;
                grant_log.push_back(gid);
                cur_cfg = req_cfg[gid*CW +: CW];
                cur_bad = exp_bad(cur_cfg);
                e   = cur_bad ? 2'd1 : (dp_en ? 2'd0 : 2'd2);
                lat = cur_bad ? 2 : (dp_en ? 4 : TO + 3);
                exp_q.push_back({gid[0], e});
                lat_q.push_back(lat);
                acc_q.push_back(cyc);
            end
            if (conv_valid_in) begin
                n_issue++;
                check_eq("issue_on_bad_cfg", cur_bad, 0);
                check_eq("issue_cfg", conv_fields(), cur_cfg);
            end
            if (rsp_valid && !rsp_prev) begin
                if (lat_q.size() == 0) begin
                    check_eq("rsp_unexpected", 1, 0);
                end else begin
                    int a, l;
                    a = acc_q.pop_front();
                    l = lat_q.pop_front();
                    check_eq("rsp_latency", cyc - a, l);
                    check_eq("rsp_cfg_hold", conv_fields(), cur_cfg);
                end
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) check_eq("rsp_no_expect", 1, 0);
                else check_eq("rsp_id_err", {rsp_id, rsp_err}, exp_q.pop_front());
            end
            rsp_prev = rsp_valid;
        end
    end

    // driver tasks; all start and end just after a rising edge
    task automatic do_reset(input int n);
        rst = 1'b1;
        req_valid = '0;
        repeat (n) @(posedge clk);
        @(negedge clk);
        check_eq("reset_outputs", {req_ready, conv_valid_in, rsp_valid, busy, rsp_err,
                 rsp_id, conv_fields(), state_dbg}, 0);
        exp_q.delete();
        lat_q.delete();
        acc_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic submit(input int id, input logic [CW-1:0] cfg);
        bit acc;
        acc = 1'b0;
        req_cfg[id*CW +: CW] = cfg;
        req_valid[id] = 1'b1;
        for (int n = 0; n < 100 && !acc; n++) begin
            @(negedge clk);
            acc = req_ready[id];
            @(posedge clk);
            #1;
        end
        req_valid[id] = 1'b0;
        check_eq("accept_timeout", acc, 1);
    endtask

    task automatic wait_done();
        bit idle;
        idle = 1'b0;
        for (int n = 0; n < 200 && !idle; n++) begin
            @(negedge clk);
            idle = !busy;
            @(posedge clk);
            #1;
        end
        check_eq("done_timeout", idle, 1);
    endtask

    task automatic stray_pulse();
        @(negedge clk);
        dp_force = 1'b1;
        @(negedge clk);
        dp_force = 1'b0;
        @(posedge clk);
        #1;
    endtask

    logic [CW-1:0] good_cfg;
    logic [CW-1:0] tbl[10];
    int            snap;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        req_valid = '0;
        req_cfg   = '0;
        rsp_ready = 1'b1;
        rst       = 1'b1;
        good_cfg  = mk(3, 1, 1, 8, 8, 1, 2, 1);
        @(posedge clk);
        #1;
        do_reset(3);

        // single job with immediate datapath answer
        snap = n_issue;
        grant_log.delete();
        submit(0, good_cfg);
        wait_done();
        check_eq("single_issue_count", n_issue - snap, 1);
        check_eq("single_grant_id", grant_log[0], 0);

        // requester 1 flickers while busy and must leave no trace
        do_reset(1);
        grant_log.delete();
        submit(0, good_cfg);
        req_valid[1] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        wait_done();
        check_eq("dropped_req_grants", grant_log.size(), 1);

        // both requesters continuously valid -> alternating grants
        do_reset(1);
        grant_log.delete();
        req_cfg   = {mk(1, 1, 0, 4, 4, 2, 3, 2), good_cfg};
        req_valid = 2'b11;
        for (int n = 0; n < 300 && grant_log.size() < 4; n++) begin
            @(posedge clk);
            #1;
        end
        req_valid = '0;
        wait_done();
        check_eq("alt_count", grant_log.size(), 4);
        for (int i = 0; i < 4; i++) check_eq("alt_grant", grant_log[i], i % 2);

        // bad descriptors, then boundary table
        snap = n_issue;
        submit(0, mk(3, 0, 1, 8, 8, 1, 2, 0));
        wait_done();
        submit(1, mk(5, 1, 0, 2, 2, 1, 2, 0));
        wait_done();
        check_eq("cfg_err_no_issue", n_issue - snap, 0);
        tbl[0] = mk(5, 1, 1, 3, 3, 1, 1, 0);
        tbl[1] = mk(5, 1, 0, 4, 5, 1, 1, 0);
        tbl[2] = mk(1, 1, 0, 32, 32, 3, 16, 3);
        tbl[3] = mk(1, 1, 0, 33, 8, 1, 1, 0);
        tbl[4] = mk(1, 1, 0, 8, 8, 4, 1, 0);
        tbl[5] = mk(1, 1, 0, 8, 8, 1, 17, 0);
        tbl[6] = mk(6, 1, 3, 8, 8, 1, 1, 0);
        tbl[7] = mk(0, 1, 0, 8, 8, 1, 1, 0);
        tbl[8] = mk(5, 2, 255, 1, 1, 2, 8, 2);
        tbl[9] = mk(1, 1, 0, 8, 8, 0, 1, 0);
        for (int i = 0; i < 10; i++) begin
            submit(i % 2, tbl[i]);
            wait_done();
        end

        // random descriptors
        for (int i = 0; i < 12; i++) begin
            submit($urandom_range(0, 1), mk($urandom_range(0, 6), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 40), $urandom_range(0, 40),
                   $urandom_range(0, 4), $urandom_range(0, 18), $urandom_range(0, 3)));
            wait_done();
        end

        // response held while rsp_ready is low
        rsp_ready = 1'b0;
        submit(1, good_cfg);
        for (int n = 0; n < 50 && !rsp_valid; n++) begin
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("hold_rsp", {rsp_valid, rsp_id, rsp_err}, 4'b1100);
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        wait_done();

        // datapath never answers
        dp_en = 1'b0;
`ifdef CONV_SCHED_TIMEOUT_EN
        submit(0, good_cfg);
        wait_done();
        dp_en = 1'b1;
        submit(1, good_cfg);
        wait_done();
`else
        submit(0, good_cfg);
        repeat (40) @(posedge clk);
        @(negedge clk);
        check_eq("no_timeout_wait", {rsp_valid, busy, state_dbg}, {1'b0, 1'b1, 3'd3});
        @(posedge clk);
        #1;
        do_reset(1);
`endif

        // reset during WAIT, then a late datapath answer
        dp_en = 1'b0;
        submit(0, good_cfg);
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("in_wait", state_dbg, 3);
        @(posedge clk);
        #1;
        do_reset(1);
        stray_pulse();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_eq("post_reset_quiet", {rsp_valid, busy}, 0);
        end
        @(posedge clk);
        #1;
        dp_en = 1'b1;

        // recovery job after all of the above
        submit(1, mk(2, 1, 0, 6, 6, 3, 4, 1));
        wait_done();

        check_eq("drain", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/conv_layer_scheduler.md
CONV_LAYER_SCHEDULER -- requirements
Module: conv_layer_scheduler

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clock port clk, reset port rst.
REQ-002 Parameter NUM_REQ, default 2: number of requesters sharing one convolution datapath.
REQ-003 Parameters MAX_IMG_HEIGHT 32, MAX_IMG_WIDTH 32, MAX_IN_CHANNELS 3, MAX_OUT_CHANNELS 16, MAX_KERNEL_SIZE 5: datapath limits used for descriptor checks.
REQ-004 Parameter TIMEOUT_CYCLES, default 1024: watchdog limit while waiting on the datapath.
REQ-005 clk  in  1  clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 req_valid  in  NUM_REQ  per-requester job-descriptor valid.
REQ-008 req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
REQ-009 req_cfg  in  NUM_REQ*58  per-requester descriptor, LSB first: kernel_size[7:0], stride, padding, img_height, img_width, in_channels, out_channels, activation[1:0].
REQ-010 conv_valid_in  out  1  one-cycle start pulse to the datapath.
REQ-011 conv_kernel_size, conv_stride, conv_padding, conv_img_height, conv_img_width, conv_in_channels, conv_out_channels  out  8 each  latched configuration.
REQ-012 conv_activation  out  2  latched activation select.
REQ-013 conv_valid_out  in  1  datapath result-valid pulse.
REQ-014 rsp_valid  out  1; rsp_ready  in  1  completion handshake.
REQ-015 rsp_id  out  $clog2(NUM_REQ) (minimum 1)  granted requester; rsp_err  out  2  0=OK, 1=CFG_ERR, 2=TIMEOUT.
REQ-016 busy  out  1  high in every state except IDLE.

Function
REQ-017 FSM states SHALL be IDLE, CHECK, ISSUE, WAIT, RESP.
REQ-018 IDLE: if any req_valid is set, assert req_ready combinationally to the round-robin winner only, latch its req_cfg and index, then go to CHECK.
REQ-019 Round-robin: requester 0 has priority after reset; after a grant to i, priority SHALL move to (i+1) mod NUM_REQ.
REQ-020 CHECK (one cycle): the descriptor is CFG_ERR if kernel_size=0, stride=0, out_channels=0, in_channels=0, kernel_size>MAX_KERNEL_SIZE, img_height>MAX_IMG_HEIGHT, img_width>MAX_IMG_WIDTH, in_channels>MAX_IN_CHANNELS, out_channels>MAX_OUT_CHANNELS, or img_height+2*padding<kernel_size or img_width+2*padding<kernel_size; all arithmetic SHALL be 10-bit unsigned, without wrap.
REQ-021 CHECK: go to RESP with rsp_err=1 on CFG_ERR and to ISSUE otherwise; no datapath pulse is issued for an erroneous descriptor.
REQ-022 ISSUE: conv_valid_in=1 for exactly one cycle, then go to WAIT.
REQ-023 The conv_* configuration outputs SHALL hold the latched values, unchanged, from CHECK through RESP.
REQ-024 WAIT: conv_valid_out=1 goes to RESP with rsp_err=0; conv_valid_out in any other state SHALL be ignored.
REQ-025 Latency: for a valid job accepted in cycle T with an immediate datapath response, rsp_valid SHALL rise in T+4; for CFG_ERR, in T+2.
REQ-026 RESP: hold rsp_valid, rsp_id and rsp_err stable until rsp_valid and rsp_ready are both high, then return to IDLE; no new grant is made in that cycle.
REQ-027 A requester that drops req_valid before its grant SHALL lose nothing and SHALL not be recorded.

Reset
REQ-028 When rst=1 at a clk edge: state IDLE, round-robin priority 0, and req_ready, conv_valid_in, rsp_valid, busy, rsp_err, rsp_id and all conv_* outputs SHALL be 0.
REQ-029 Reset mid-job SHALL abandon the job silently, with no rsp_valid, and SHALL ignore any later conv_valid_out.

Configuration
REQ-030 With macro CONV_SCHED_TIMEOUT_EN defined, a WAIT cycle counter (cleared on entry) SHALL force RESP with rsp_err=2 when it reaches TIMEOUT_CYCLES without conv_valid_out.
REQ-031 Without CONV_SCHED_TIMEOUT_EN, WAIT SHALL wait indefinitely, no counter logic SHALL be present, and rsp_err=2 SHALL never occur.

Structure
REQ-032 Package conv_sched_pkg SHALL hold the state enum, the rsp_err codes, CFG_W=58 and the field offsets within req_cfg.
REQ-033 Round-robin grant logic SHALL be a separate sub-module, conv_rr_arbiter, parameterised on NUM_REQ.

Verification
REQ-034 Single job, req0 descriptor {k=3,s=1,p=1,h=8,w=8,ic=1,oc=2}, datapath model answering one cycle after conv_valid_in -> one conv_valid_in pulse, rsp_valid 4 cycles after accept, rsp_id=0, rsp_err=0.
REQ-035 req0 and req1 both valid continuously with rsp_ready=1 -> grants alternate 0,1,0,1; exactly one req_ready bit high per grant.
REQ-036 Descriptor with stride=0, then one with k=5, h=2, w=2, p=0 -> rsp_err=1 two cycles after accept, conv_valid_in never asserted.
REQ-037 With CONV_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=16, datapath never answers -> rsp_err=2 after 16 WAIT cycles, then the next job proceeds normally.
REQ-038 rst pulsed during WAIT, then a late conv_valid_out -> all outputs 0, no rsp_valid; a stray conv_valid_out in IDLE is ignored; rsp_ready held low for 5 cycles keeps rsp_valid, rsp_id and rsp_err stable.
